// File: rtl/fifo_drain.sv
// rtl/fifo_drain.sv - Drains a FIFO with one-cycle read latency into a valid/ready stream.
// Optional saturating transfer counter enabled by FIFO_DRAIN_STATS_EN.
module fifo_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_enable,
    input  logic                  i_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    output logic                  o_rd_en,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ready,
    output logic                  o_busy,
    output logic [CNT_WIDTH-1:0]  o_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] q0_q, q0_d;
    logic [DATA_WIDTH-1:0] q1_q, q1_d;

    logic       pop;
    logic       rd_en;
    logic [2:0] credit;

    // A read is only issued if its word is guaranteed a queue slot on capture.
    always_comb begin
        pop    = (occ_q != 2'd0) & i_ready & ~rst;
        credit = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        rd_en  = i_enable & ~i_empty & (state_q == S_RUN) & (credit < 3'd2) & ~rst;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_enable) state_d = S_RUN;
            end
            S_RUN: begin
                if (!i_enable) begin
                    if ((occ_q != 2'd0) || inflight_q) state_d = S_DRAIN;
                    else                               state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (i_enable)                              state_d = S_RUN;
                else if ((occ_q == 2'd0) && !inflight_q)   state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // q0 is the head; a capture lands at index (occ - pop).
    always_comb begin
        q0_d       = q0_q;
        q1_d       = q1_q;
        occ_d      = occ_q;
        inflight_d = rd_en;
        case ({inflight_q, pop})
            2'b10: begin
                if (occ_q == 2'd0) q0_d = i_fifo_data;
                else               q1_d = i_fifo_data;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                q0_d  = q1_q;
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    q0_d = i_fifo_data;
                end else begin
                    q0_d = q1_q;
                    q1_d = i_fifo_data;
                end
            end
            default: begin
                q0_d = q0_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            q0_q       <= '0;
            q1_q       <= '0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            q0_q       <= q0_d;
            q1_q       <= q1_d;
        end
    end

    // Outputs are forced quiet for the whole cycle in which rst is high.
    assign o_rd_en = rd_en;
    assign o_valid = (occ_q != 2'd0) & ~rst;
    assign o_data  = rst ? '0 : q0_q;
    assign o_busy  = (state_q != S_IDLE) & ~rst;

`ifdef FIFO_DRAIN_STATS_EN
    logic [CNT_WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (pop && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_q <= count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign o_count = rst ? '0 : count_q;
`else
    assign o_count = '0;
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// tb/tb_fifo_drain.sv - Directed and random checks of fifo_drain against a word-level FIFO/scoreboard model.
module tb_fifo_drain;
    localparam int DW = 8;
    localparam int CW = 4;
`ifdef FIFO_DRAIN_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, i_enable, i_empty, i_ready;
    logic [DW-1:0] i_fifo_data;
    logic          o_rd_en, o_valid, o_busy;
    logic [DW-1:0] o_data;
    logic [CW-1:0] o_count;

    always #5 clk = ~clk;

    fifo_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .i_enable(i_enable), .i_empty(i_empty),
        .i_fifo_data(i_fifo_data), .o_rd_en(o_rd_en), .o_valid(o_valid),
        .o_data(o_data), .i_ready(i_ready), .o_busy(o_busy), .o_count(o_count)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fifo_q[$];   // upstream FIFO contents
    logic [DW-1:0] sb[$];       // words read from FIFO, not yet delivered
    logic [DW-1:0] got[$];      // words delivered downstream
    logic [DW-1:0] pend;
    bit            have_pend = 1'b0;
    int            cnt_exp = 0;
    bit            prev_v = 1'b0, prev_rdy = 1'b0, prev_rst = 1'b1;
    logic [DW-1:0] prev_d;
    int            cyc = 0;
    int            rd_cnt, rd_first, rd_last, x_first, x_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit en, input bit rdy);
        @(negedge clk);
        if (have_pend) i_fifo_data = pend;
        else           i_fifo_data = DW'($urandom);
        have_pend = 1'b0;
        rst      = r;
        i_enable = en;
        i_ready  = rdy;
        i_empty  = (fifo_q.size() == 0);
        #1;
        chk("no_rd_while_empty", {31'd0, o_rd_en & i_empty}, 32'd0);
        if (r) begin
            sb.delete();
            cnt_exp = 0;
            chk("rst_outputs", {27'd0, o_rd_en, o_valid, o_busy, (o_data != 0), (o_count != 0)}, 32'd0);
        end else begin
            chk("count", {28'd0, o_count}, STATS ? cnt_exp : 0);
            if (prev_v && !prev_rdy && !prev_rst) begin
                chk("hold_valid", {31'd0, o_valid}, 32'd1);
                chk("hold_data", {24'd0, o_data}, {24'd0, prev_d});
            end
            if (o_valid && i_ready) begin
                chk("xfer_expected", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) chk("xfer_data", {24'd0, o_data}, {24'd0, sb.pop_front()});
                got.push_back(o_data);
                if (cnt_exp < (1 << CW) - 1) cnt_exp++;
                if (x_first < 0) x_first = cyc;
                x_last = cyc;
            end
            if (o_rd_en && fifo_q.size() != 0) begin
                pend      = fifo_q.pop_front();
                have_pend = 1'b1;
                sb.push_back(pend);
                rd_cnt++;
                if (rd_first < 0) rd_first = cyc;
                rd_last = cyc;
            end
            chk("outstanding_le2", {31'd0, sb.size() <= 2}, 32'd1);
        end
        prev_v   = o_valid;
        prev_rdy = i_ready;
        prev_d   = o_data;
        prev_rst = r;
        cyc++;
    endtask

    task automatic restart(input int nwords);
        fifo_q.delete();
        cycle(1'b1, 1'b0, 1'b0);
        got.delete();
        rd_cnt = 0; rd_first = -1; rd_last = -1; x_first = -1; x_last = -1;
        for (int i = 1; i <= nwords; i++) fifo_q.push_back(DW'(10 * i));
    endtask

    initial begin
        rst = 1'b1; i_enable = 1'b0; i_ready = 1'b0; i_empty = 1'b1; i_fifo_data = '0;

        // Streaming: three words back-to-back.
        restart(3);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1);
        chk("t1_rd_count", rd_cnt, 3);
        chk("t1_rd_consecutive", rd_last - rd_first, 2);
        chk("t1_first_valid_lat", x_first - rd_first, 2);
        chk("t1_xfer_consecutive", x_last - x_first, 2);
        chk("t1_words", {got.size() == 3 && got[0] == 10 && got[1] == 20 && got[2] == 30}, 1);
        chk("t1_valid_off", {31'd0, o_valid}, 0);

        // Backpressure: reads stop at two outstanding, head held.
        restart(4);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0);
        chk("t2_rd_count", rd_cnt, 2);
        chk("t2_valid_held", {31'd0, o_valid}, 1);
        chk("t2_data_held", {24'd0, o_data}, 10);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1);
        chk("t2_words", {got.size() == 4 && got[0] == 10 && got[1] == 20 && got[2] == 30 && got[3] == 40}, 1);

        // Empty FIFO: stays in RUN, never reads.
        restart(0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1);
        chk("t3_rd_count", rd_cnt, 0);
        chk("t3_valid", {31'd0, o_valid}, 0);
        chk("t3_busy", {31'd0, o_busy}, 1);

        // Drain: enable dropped with one queued and one in flight.
        restart(4);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("t4_busy_at_drop", {31'd0, o_busy}, 1);
        cycle(1'b0, 1'b0, 1'b1);
        chk("t4_busy_drain", {31'd0, o_busy}, 1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1);
        chk("t4_rd_count", rd_cnt, 2);
        chk("t4_words", {got.size() == 2 && got[0] == 10 && got[1] == 20}, 1);
        chk("t4_idle", {31'd0, o_busy}, 0);

        // Reset mid-operation discards queued words.
        restart(4);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0);
        chk("t5_full", {31'd0, o_valid}, 1);
        cycle(1'b1, 1'b0, 1'b0);
        got.delete();
        cycle(1'b0, 1'b0, 1'b1);
        chk("t5_valid", {31'd0, o_valid}, 0);
        chk("t5_count", {28'd0, o_count}, 0);
        chk("t5_busy", {31'd0, o_busy}, 0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1);
        chk("t5_no_stale", got.size(), 0);

        // Counter saturation after 20 transfers.
        restart(20);
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, 1'b1);
        chk("t6_words", got.size(), 20);
        chk("t6_count_sat", {28'd0, o_count}, STATS ? 15 : 0);

        // Random traffic with occasional resets.
        restart(0);
        for (int i = 0; i < 30; i++) fifo_q.push_back(DW'($urandom));
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0 && fifo_q.size() < 8) fifo_q.push_back(DW'($urandom));
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1);
        chk("rand_drained", sb.size(), 0);
        chk("rand_idle", {31'd0, o_busy}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width of FIFO and stream data.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of delivered-word counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_enable  input  1  permits issuing new FIFO reads.
REQ-006 SHALL have port i_empty  input  1  FIFO empty flag.
REQ-007 SHALL have port i_fifo_data  input  DATA_WIDTH  FIFO read data, valid cycle after o_rd_en.
REQ-008 SHALL have port o_rd_en  output  1  FIFO read strobe.
REQ-009 SHALL have port o_valid  output  1  downstream word valid.
REQ-010 SHALL have port o_data  output  DATA_WIDTH  downstream word.
REQ-011 SHALL have port i_ready  input  1  downstream accepts word.
REQ-012 SHALL have port o_busy  output  1  state not IDLE.
REQ-013 SHALL have port o_count  output  CNT_WIDTH  delivered-word count.

Function
REQ-014 SHALL hold a 2-entry in-order output queue (occupancy 0..2) plus 1-bit in-flight flag for an issued, uncaptured read.
REQ-015 SHALL drive o_rd_en = i_enable & !i_empty & state==RUN & (occupancy + inflight - pop) < 2, pop = o_valid & i_ready; never high while i_empty.
REQ-016 SHALL set inflight on edge after o_rd_en high; SHALL capture i_fifo_data into queue tail on the following edge regardless of i_empty or i_enable at that time.
REQ-017 SHALL assert o_valid whenever occupancy > 0, o_data = queue head; first o_valid two cycles after first o_rd_en.
REQ-018 SHALL hold o_valid and o_data stable while o_valid & !i_ready.
REQ-019 SHALL handle simultaneous capture and pop in one cycle with occupancy unchanged and order preserved.
REQ-020 SHALL sustain one word per cycle with i_ready high and FIFO non-empty.
REQ-021 SHALL implement states IDLE, RUN, DRAIN.
REQ-022 IDLE->RUN when i_enable high; RUN->DRAIN when i_enable low and (occupancy>0 or inflight); RUN->IDLE when i_enable low and nothing buffered/inflight; DRAIN->IDLE when occupancy==0 and !inflight; DRAIN->RUN when i_enable high.
REQ-023 SHALL issue no reads in IDLE or DRAIN; DRAIN delivers buffered/inflight words only.

Reset
REQ-024 SHALL, while rst high, force state IDLE, occupancy 0, inflight 0, o_count 0; outputs o_rd_en 0, o_valid 0, o_data 0, o_busy 0.
REQ-025 SHALL discard queued and inflight words on reset mid-operation; i_fifo_data in the cycle after reset release SHALL NOT be captured.

Configuration
REQ-026 With FIFO_DRAIN_STATS_EN defined, o_count SHALL increment by 1 per accepted transfer (o_valid & i_ready), saturating at all-ones.
REQ-027 Without FIFO_DRAIN_STATS_EN, o_count SHALL be constant 0 and no counter register SHALL be synthesized.

Verification
REQ-028 FIFO model preloaded 10,20,30, i_enable=1, i_ready=1 -> o_rd_en high 3 consecutive cycles; o_data 10,20,30 on 3 consecutive o_valid cycles; then o_valid 0.
REQ-029 4 words preloaded, i_ready=0 for 6 cycles -> exactly 2 reads issued, o_valid=1, o_data=10 held; i_ready=1 -> 10,20,30,40 delivered in order, none lost.
REQ-030 i_empty=1 throughout, i_enable=1 -> o_rd_en never high, o_valid 0, state RUN, o_busy 1.
REQ-031 i_enable dropped with 1 word queued and 1 inflight -> state DRAIN, no further o_rd_en, both words delivered, then IDLE, o_busy 0.
REQ-032 rst pulsed 1 cycle with 2 queued words -> next cycle o_valid 0, o_count 0, state IDLE; stale word not delivered.
REQ-033 FIFO_DRAIN_STATS_EN defined, CNT_WIDTH=4, 20 transfers -> o_count=15; macro undefined -> o_count=0.
